fpu_wb_sched: RTL

Writeback-slot scheduler for the three FPU issue lanes (u1, u3, u5). Each lane asks to issue an FP op with a known pipeline latency. The block grants issue only when a shared writeback bus is free in the cycle the result will emerge, and drives per-cycle bus-enable and lane-tag outputs to the result muxes. It sits between the FP issue queues and the FPU datapath and replaces ad-hoc per-lane writeback collision handling.

---
 rtl/fpu_wb_sched_if.sv | 26 ++
 rtl/fpu_wb_sched.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fpu_wb_sched_if.sv
// Issue/writeback interface for fpu_wb_sched: lane requests and latencies in,
// grants plus the registered writeback-bus view out.
interface fpu_wb_sched_if #(
  parameter int unsigned NWB = 2
) ();
  logic [2:0]       req;
  logic [2:0]       lat0;
  logic [2:0]       lat1;
  logic [2:0]       lat2;
  logic             flush;
  logic [2:0]       gnt;
  logic [NWB-1:0]   wb_en;
  logic [2*NWB-1:0] wb_lane;
  logic             busy;
  logic             lat_err;

  modport master (
    output req, lat0, lat1, lat2, flush,
    input  gnt, wb_en, wb_lane, busy, lat_err
  );

  modport slave (
    input  req, lat0, lat1, lat2, flush,
    output gnt, wb_en, wb_lane, busy, lat_err
  );
endinterface

// File: rtl/fpu_wb_sched.sv
// Writeback-slot scheduler for FPU lanes u1/u3/u5 using a MAXLAT-deep reservation ring.
// Optional starvation override: define FPU_WB_SCHED_STARVE_EN.
module fpu_wb_sched #(
  parameter int unsigned MAXLAT = 6,
  parameter int unsigned NWB    = 2
) (
  input logic          clk,
  input logic          rst,
  fpu_wb_sched_if.slave bus
);

  logic [NWB-1:0]        r_occ [1:MAXLAT];
  logic [NWB-1:0][1:0]   r_tag [1:MAXLAT];
  logic [1:0]            r_rr;
  logic [NWB-1:0]        r_wb_en;
  logic [2*NWB-1:0]      r_wb_lane;
  logic                  r_busy;
  logic                  r_lat_err;

  logic [NWB-1:0]        w_occ [1:MAXLAT];
  logic [NWB-1:0][1:0]   w_tag [1:MAXLAT];
  logic [1:0]            w_ord [3];
  logic [2:0]            w_lat [3];
  logic [2:0]            w_gnt;
  logic [2:0]            w_ill;
  logic                  w_any;
  logic [1:0]            w_first;
  logic                  w_found;
  logic                  w_busy;
  logic [1:0]            w_lane;
  logic [2:0]            w_l;

`ifdef FPU_WB_SCHED_STARVE_EN
  logic [2:0]            r_cnt [3];
  logic                  w_st_any;
  logic [1:0]            w_st;
  logic [1:0]            w_n;
`endif

  always_comb begin
    w_lat[0] = bus.lat0;
    w_lat[1] = bus.lat1;
    w_lat[2] = bus.lat2;
    for (int unsigned p = 0; p < 3; p++) w_ord[p] = 2'((32'(r_rr) + p) % 3);
`ifdef FPU_WB_SCHED_STARVE_EN
    // A saturated lane jumps to the head; the rest keep round-robin order behind it.
    w_st_any = 1'b0;
    w_st     = '0;
    w_n      = '0;
    for (int unsigned l = 3; l > 0; l--) begin
      if (r_cnt[l-1] == 3'd7) begin
        w_st_any = 1'b1;
        w_st     = 2'(l - 1);
      end
    end
    if (w_st_any) begin
      w_ord[0] = w_st;
      w_n      = 2'd1;
      for (int unsigned p = 0; p < 3; p++) begin
        w_lane = 2'((32'(r_rr) + p) % 3);
        if (w_lane != w_st) begin
          w_ord[w_n] = w_lane;
          w_n        = w_n + 2'd1;
        end
      end
    end
`endif
    w_occ   = r_occ;
    w_tag   = r_tag;
    w_gnt   = '0;
    w_ill   = '0;
    w_any   = 1'b0;
    w_first = '0;
    w_found = 1'b0;
    w_lane  = '0;
    w_l     = '0;
    for (int unsigned p = 0; p < 3; p++) begin
      w_lane = w_ord[p];
      w_l    = w_lat[w_lane];
      if (bus.req[w_lane] && (w_l == 3'd0 || 32'(w_l) > MAXLAT)) w_ill[w_lane] = 1'b1;
      if (!rst && !bus.flush && bus.req[w_lane] && w_l != 3'd0 && 32'(w_l) <= MAXLAT) begin
        w_found = 1'b0;
        for (int unsigned k = 0; k < NWB; k++) begin
          if (!w_found && !w_occ[w_l][k]) begin
            w_found        = 1'b1;
            w_occ[w_l][k]  = 1'b1;
            w_tag[w_l][k]  = w_lane;
          end
        end
        if (w_found) begin
          w_gnt[w_lane] = 1'b1;
          if (!w_any) begin
            w_any   = 1'b1;
            w_first = w_lane;
          end
        end
      end
    end
    w_busy = 1'b0;
    for (int unsigned j = 1; j <= MAXLAT; j++) w_busy = w_busy | (|w_occ[j]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 1; j <= MAXLAT; j++) begin
        r_occ[j] <= '0;
        r_tag[j] <= '1;
      end
      r_rr      <= '0;
      r_wb_en   <= '0;
      r_wb_lane <= '1;
      r_busy    <= 1'b0;
      r_lat_err <= 1'b0;
    end else if (bus.flush) begin
      for (int unsigned j = 1; j <= MAXLAT; j++) begin
        r_occ[j] <= '0;
        r_tag[j] <= '1;
      end
      r_wb_en   <= '0;
      r_wb_lane <= '1;
      r_busy    <= 1'b0;
      r_lat_err <= r_lat_err | (|w_ill);
    end else begin
      // Slot 1 (with this cycle's L=1 grants) becomes next cycle's bus view.
      for (int unsigned k = 0; k < NWB; k++)
        r_wb_lane[2*k +: 2] <= w_occ[1][k] ? w_tag[1][k] : 2'd3;
      r_wb_en <= w_occ[1];
      for (int unsigned j = 1; j < MAXLAT; j++) begin
        r_occ[j] <= w_occ[j+1];
        r_tag[j] <= w_tag[j+1];
      end
      r_occ[MAXLAT] <= '0;
      r_tag[MAXLAT] <= '1;
      r_busy        <= w_busy;
      r_lat_err     <= r_lat_err | (|w_ill);
      if (w_any) r_rr <= (w_first == 2'd2) ? 2'd0 : w_first + 2'd1;
    end
  end

`ifdef FPU_WB_SCHED_STARVE_EN
  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < 3; l++) begin
      if (rst || bus.flush || !bus.req[l] || w_gnt[l]) r_cnt[l] <= '0;
      else if (r_cnt[l] != 3'd7)                       r_cnt[l] <= r_cnt[l] + 3'd1;
    end
  end
`endif

  assign bus.gnt     = w_gnt;
  assign bus.wb_en   = r_wb_en;
  assign bus.wb_lane = r_wb_lane;
  assign bus.busy    = r_busy;
  assign bus.lat_err = r_lat_err;

endmodule
